// File: rtl/uart_rx_ctrl_gen2.sv
// UART receive frame controller: oversampling edge/bit counters, frame FSM and checker enables.
// Define UART_RX_BREAK_DET_EN to compile in line-break detection (break_det output, BREAK_WAIT state).
module uart_rx_ctrl_gen2 #(
    parameter int DATA_WIDTH = 8,
    parameter int PS_W       = 6,
    parameter int BC_W       = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            RX_IN,
    input  logic            PAR_EN,
    input  logic            STOP2_EN,
    input  logic [PS_W-1:0] PRESCALE,
    input  logic            sampled_bit,
    input  logic            strt_glitch,
    input  logic            par_err,
    input  logic            stp_err,
    output logic [PS_W-1:0] edge_cnt,
    output logic [BC_W-1:0] bit_cnt,
    output logic            dat_samp_en,
    output logic            strt_chk_en,
    output logic            deser_en,
    output logic            par_chk_en,
    output logic            stp_chk_en,
    output logic            data_valid,
    output logic            frame_err,
`ifdef UART_RX_BREAK_DET_EN
    output logic            break_det,
`endif
    output logic            busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_ERR_CHK,
        S_VALID
`ifdef UART_RX_BREAK_DET_EN
        , S_BREAK_WAIT
`endif
    } state_e;

    state_e          state_q;
    logic [PS_W-1:0] edge_cnt_q;
    logic [BC_W-1:0] bit_cnt_q;
    logic [PS_W-1:0] prescale_q;
    logic            par_en_q;
    logic            stop2_en_q;
    logic            data_valid_q;
    logic            frame_err_q;

    logic [PS_W-1:0] prescale_d;
    logic [PS_W-1:0] last_edge_s;
    logic [BC_W-1:0] last_stop_s;
    logic            edge_wrap_s;
    logic [PS_W-1:0] edge_adv_s;
    logic [BC_W-1:0] bit_adv_s;
    logic            start_s;

    // Ratios below 4 leave no room for a mid-bit sample, so they are clamped.
    assign prescale_d  = (PRESCALE < PS_W'(4)) ? PS_W'(4) : PRESCALE;
    assign last_edge_s = prescale_q - PS_W'(1);
    assign last_stop_s = BC_W'(DATA_WIDTH + 1) + BC_W'(par_en_q) + BC_W'(stop2_en_q);
    assign edge_wrap_s = (edge_cnt_q == last_edge_s);
    assign edge_adv_s  = edge_wrap_s ? '0 : edge_cnt_q + PS_W'(1);
    assign bit_adv_s   = edge_wrap_s ? bit_cnt_q + BC_W'(1) : bit_cnt_q;
    assign start_s     = ((state_q == S_IDLE) || (state_q == S_VALID)) && !RX_IN;

    // Per-frame configuration snapshot, taken on every entry into START.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prescale_q <= '0;
            par_en_q   <= 1'b0;
            stop2_en_q <= 1'b0;
        end else if (start_s) begin
            prescale_q <= prescale_d;
            par_en_q   <= PAR_EN;
            stop2_en_q <= STOP2_EN;
        end
    end

`ifdef UART_RX_BREAK_DET_EN
    logic all_zero_q;
    logic break_det_q;

    // Sticky flag: every bit of the frame so far was sampled low.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            all_zero_q <= 1'b0;
        end else if (start_s) begin
            all_zero_q <= 1'b1;
        end else if ((state_q inside {S_START, S_DATA, S_PARITY, S_STOP}) && edge_wrap_s) begin
            all_zero_q <= all_zero_q & ~sampled_bit;
        end
    end

    assign break_det = break_det_q;
`endif

    // Frame FSM with its counters and the registered result pulses.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= S_IDLE;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            break_det_q  <= 1'b0;
`endif
        end else begin
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            break_det_q  <= 1'b0;
`endif
            case (state_q)
                S_IDLE, S_VALID: begin
                    edge_cnt_q <= '0;
                    bit_cnt_q  <= '0;
                    state_q    <= start_s ? S_START : S_IDLE;
                end
                S_START: begin
                    edge_cnt_q <= edge_adv_s;
                    bit_cnt_q  <= bit_adv_s;
                    if (edge_wrap_s && strt_glitch) begin
                        bit_cnt_q <= '0;
                        state_q   <= S_IDLE;
                    end else if (edge_wrap_s) begin
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    edge_cnt_q <= edge_adv_s;
                    bit_cnt_q  <= bit_adv_s;
                    if (edge_wrap_s && (bit_cnt_q == BC_W'(DATA_WIDTH))) begin
                        state_q <= par_en_q ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    edge_cnt_q <= edge_adv_s;
                    bit_cnt_q  <= bit_adv_s;
                    if (edge_wrap_s) begin
                        state_q <= S_STOP;
                    end
                end
                S_STOP: begin
                    edge_cnt_q <= edge_adv_s;
                    bit_cnt_q  <= bit_adv_s;
                    if (edge_wrap_s && (bit_cnt_q == last_stop_s)) begin
                        bit_cnt_q <= '0;
                        state_q   <= S_ERR_CHK;
                    end
                end
                S_ERR_CHK: begin
                    edge_cnt_q <= '0;
                    bit_cnt_q  <= '0;
`ifdef UART_RX_BREAK_DET_EN
                    if (all_zero_q && stp_err) begin
                        break_det_q <= 1'b1;
                        state_q     <= S_BREAK_WAIT;
                    end else
`endif
                    if (par_err || stp_err) begin
                        frame_err_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        data_valid_q <= 1'b1;
                        state_q      <= S_VALID;
                    end
                end
`ifdef UART_RX_BREAK_DET_EN
                S_BREAK_WAIT: begin
                    edge_cnt_q <= '0;
                    bit_cnt_q  <= '0;
                    state_q    <= RX_IN ? S_IDLE : S_BREAK_WAIT;
                end
`endif
                default: begin
                    edge_cnt_q <= '0;
                    bit_cnt_q  <= '0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    // Checker enables decoded from state; IDLE arms the sampler as soon as the line drops.
    always_comb begin
        dat_samp_en = 1'b0;
        strt_chk_en = 1'b0;
        deser_en    = 1'b0;
        par_chk_en  = 1'b0;
        stp_chk_en  = 1'b0;
        case (state_q)
            S_IDLE: begin
                dat_samp_en = ~RX_IN & ~RST;
                strt_chk_en = ~RX_IN & ~RST;
            end
            S_START: begin
                dat_samp_en = 1'b1;
                strt_chk_en = 1'b1;
            end
            S_DATA: begin
                dat_samp_en = 1'b1;
                deser_en    = 1'b1;
            end
            S_PARITY: begin
                dat_samp_en = 1'b1;
                par_chk_en  = 1'b1;
            end
            S_STOP: begin
                dat_samp_en = 1'b1;
                stp_chk_en  = 1'b1;
            end
            S_ERR_CHK: begin
                dat_samp_en = 1'b1;
            end
            default: begin
                dat_samp_en = 1'b0;
            end
        endcase
    end

    assign edge_cnt   = edge_cnt_q;
    assign bit_cnt    = bit_cnt_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl_gen2.sv
// Directed self-checking bench for uart_rx_ctrl_gen2 (DATA_WIDTH=8); break tests build only with UART_RX_BREAK_DET_EN.
module tb_uart_rx_ctrl_gen2;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN;
    logic       STOP2_EN;
    logic [5:0] PRESCALE;
    logic       sampled_bit;
    logic       strt_glitch;
    logic       par_err;
    logic       stp_err;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       dat_samp_en;
    logic       strt_chk_en;
    logic       deser_en;
    logic       par_chk_en;
    logic       stp_chk_en;
    logic       data_valid;
    logic       frame_err;
    logic       busy;
`ifdef UART_RX_BREAK_DET_EN
    logic       break_det;
`endif

    int n_cmp = 0;
    int n_err = 0;

    uart_rx_ctrl_gen2 #(.DATA_WIDTH(8), .PS_W(6), .BC_W(4)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .STOP2_EN(STOP2_EN),
        .PRESCALE(PRESCALE), .sampled_bit(sampled_bit), .strt_glitch(strt_glitch),
        .par_err(par_err), .stp_err(stp_err), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
        .dat_samp_en(dat_samp_en), .strt_chk_en(strt_chk_en), .deser_en(deser_en),
        .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en), .data_valid(data_valid),
        .frame_err(frame_err),
`ifdef UART_RX_BREAK_DET_EN
        .break_det(break_det),
`endif
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Walks a frame from START edge 0 for ncyc cycles, checking counters and enables every cycle.
    task automatic walk_frame(input int p, input bit par, input bit stp2, input logic [7:0] data,
                              input int ncyc, input bit brk);
        int b;
        int e;
        logic [7:0] exp_v;
        logic [7:0] obs_v;
        logic line;
        for (int c = 0; c < ncyc; c++) begin
            b = c / p;
            e = c % p;
            n_cmp++;
            if (edge_cnt !== 6'(e) || bit_cnt !== 4'(b)) begin
                n_err++;
                $display("FAIL walk_cnt c=%0d: got edge=%0d bit=%0d, want edge=%0d bit=%0d",
                         c, edge_cnt, bit_cnt, e, b);
            end
            exp_v = {1'b1, 1'b1, (b == 0), (b >= 1 && b <= 8), (par && b == 9),
                     (b >= 9 + int'(par) && b <= 9 + int'(par) + int'(stp2)), 1'b0, 1'b0};
            obs_v = {busy, dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en,
                     data_valid, frame_err};
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_err++;
                $display("FAIL walk_en c=%0d: got %b want %b (busy,samp,strt,deser,par,stp,dv,fe)",
                         c, obs_v, exp_v);
            end
            if (brk || b == 0) line = 1'b0;
            else if (b <= 8) line = data[3'(b - 1)];
            else line = 1'b1;
            RX_IN       = line;
            sampled_bit = line;
            if (c < ncyc - 1) step();
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; RX_IN = 1'b0; PAR_EN = 1'b0; STOP2_EN = 1'b0; PRESCALE = 6'd8;
        sampled_bit = 1'b1; strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        step();
        step();
        n_cmp++;
        if ({edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en,
             data_valid, frame_err, busy} !== 18'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got edge=%0d bit=%0d samp=%b strt=%b busy=%b, want all 0",
                     edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, busy);
        end
        RX_IN = 1'b1;
        RST   = 1'b0;
        step();
        n_cmp++;
        if (busy !== 1'b0 || dat_samp_en !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: got busy=%b samp=%b, want 0 0", busy, dat_samp_en);
        end
    endtask

    task automatic test_frame_8n1();
        PRESCALE = 6'd8; PAR_EN = 1'b0; STOP2_EN = 1'b0;
        RX_IN = 1'b0;
        #1;
        n_cmp++;
        if ({dat_samp_en, strt_chk_en, busy} !== 3'b110) begin
            n_err++;
            $display("FAIL idle_arm: got samp,strt,busy=%b want 110", {dat_samp_en, strt_chk_en, busy});
        end
        step();
        walk_frame(8, 1'b0, 1'b0, 8'hA5, 80, 1'b0);
        step();
        n_cmp++;
        if ({busy, dat_samp_en, stp_chk_en, data_valid, bit_cnt, edge_cnt} !== {4'b1100, 4'd0, 6'd0}) begin
            n_err++;
            $display("FAIL errchk_8n1: got busy=%b samp=%b stp=%b dv=%b bit=%0d edge=%0d want 1 1 0 0 0 0",
                     busy, dat_samp_en, stp_chk_en, data_valid, bit_cnt, edge_cnt);
        end
        step();
        n_cmp++;
        if ({data_valid, frame_err, busy} !== 3'b101) begin
            n_err++;
            $display("FAIL valid_8n1: got dv,fe,busy=%b want 101", {data_valid, frame_err, busy});
        end
        step();
        n_cmp++;
        if ({data_valid, frame_err, busy} !== 3'b000) begin
            n_err++;
            $display("FAIL idle_after_8n1: got dv,fe,busy=%b want 000", {data_valid, frame_err, busy});
        end
    endtask

    task automatic test_parity_err();
        PRESCALE = 6'd16; PAR_EN = 1'b1; STOP2_EN = 1'b1;
        RX_IN = 1'b0;
        step();
        walk_frame(16, 1'b1, 1'b1, 8'h3C, 192, 1'b0);
        step();
        n_cmp++;
        if ({busy, dat_samp_en, stp_chk_en, par_chk_en} !== 4'b1100) begin
            n_err++;
            $display("FAIL errchk_par: got busy,samp,stp,par=%b want 1100",
                     {busy, dat_samp_en, stp_chk_en, par_chk_en});
        end
        par_err = 1'b1;
        step();
        par_err = 1'b0;
        n_cmp++;
        if ({frame_err, data_valid, busy} !== 3'b100) begin
            n_err++;
            $display("FAIL par_frame_err: got fe,dv,busy=%b want 100", {frame_err, data_valid, busy});
        end
        step();
        n_cmp++;
        if ({frame_err, data_valid, busy} !== 3'b000) begin
            n_err++;
            $display("FAIL par_pulse_width: got fe,dv,busy=%b want 000", {frame_err, data_valid, busy});
        end
        PAR_EN = 1'b0; STOP2_EN = 1'b0;
    endtask

    task automatic test_glitch();
        PRESCALE = 6'd8;
        RX_IN = 1'b0;
        step();
        for (int c = 0; c < 8; c++) begin
            n_cmp++;
            if (edge_cnt !== 6'(c) || busy !== 1'b1 || strt_chk_en !== 1'b1) begin
                n_err++;
                $display("FAIL glitch_start c=%0d: got edge=%0d busy=%b strt=%b", c, edge_cnt, busy, strt_chk_en);
            end
            if (c == 1) RX_IN = 1'b1;
            if (c == 7) strt_glitch = 1'b1;
            if (c < 7) step();
        end
        step();
        strt_glitch = 1'b0;
        n_cmp++;
        if ({busy, data_valid, frame_err, bit_cnt, edge_cnt} !== 13'd0) begin
            n_err++;
            $display("FAIL glitch_idle: got busy=%b dv=%b fe=%b bit=%0d edge=%0d want all 0",
                     busy, data_valid, frame_err, bit_cnt, edge_cnt);
        end
        step();
        n_cmp++;
        if ({busy, data_valid, frame_err} !== 3'b000) begin
            n_err++;
            $display("FAIL glitch_quiet: got busy,dv,fe=%b want 000", {busy, data_valid, frame_err});
        end
    endtask

    task automatic test_clamp();
        PRESCALE = 6'd2;
        RX_IN = 1'b0;
        step();
        walk_frame(4, 1'b0, 1'b0, 8'h5A, 40, 1'b0);
        step();
        step();
        n_cmp++;
        if ({data_valid, frame_err} !== 2'b10) begin
            n_err++;
            $display("FAIL clamp_valid: got dv,fe=%b want 10", {data_valid, frame_err});
        end
        RX_IN = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        PRESCALE = 6'd8;
        RX_IN = 1'b0;
        step();
        walk_frame(8, 1'b0, 1'b0, 8'h11, 80, 1'b0);
        step();
        RX_IN = 1'b0;
        step();
        n_cmp++;
        if (data_valid !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_valid1: got dv=%b want 1", data_valid);
        end
        step();
        n_cmp++;
        if ({busy, strt_chk_en, data_valid, bit_cnt, edge_cnt} !== {3'b110, 4'd0, 6'd0}) begin
            n_err++;
            $display("FAIL b2b_restart: got busy=%b strt=%b dv=%b bit=%0d edge=%0d want 1 1 0 0 0",
                     busy, strt_chk_en, data_valid, bit_cnt, edge_cnt);
        end
        walk_frame(8, 1'b0, 1'b0, 8'h22, 80, 1'b0);
        step();
        RX_IN = 1'b1;
        step();
        n_cmp++;
        if (data_valid !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_valid2: got dv=%b want 1", data_valid);
        end
        step();
        n_cmp++;
        if ({busy, data_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL b2b_idle: got busy,dv=%b want 00", {busy, data_valid});
        end
    endtask

    task automatic test_prescale_change_reset();
        PRESCALE = 6'd8; PAR_EN = 1'b0; STOP2_EN = 1'b0;
        RX_IN = 1'b0;
        step();
        PRESCALE = 6'd16; PAR_EN = 1'b1; STOP2_EN = 1'b1;
        walk_frame(8, 1'b0, 1'b0, 8'hC3, 80, 1'b0);
        step();
        n_cmp++;
        if ({busy, stp_chk_en, par_chk_en, bit_cnt} !== {3'b100, 4'd0}) begin
            n_err++;
            $display("FAIL cfg_held: got busy=%b stp=%b par=%b bit=%0d want 1 0 0 0",
                     busy, stp_chk_en, par_chk_en, bit_cnt);
        end
        RX_IN = 1'b1;
        step();
        n_cmp++;
        if (data_valid !== 1'b1) begin
            n_err++;
            $display("FAIL cfg_held_valid: got dv=%b want 1", data_valid);
        end
        step();
        PAR_EN = 1'b0; STOP2_EN = 1'b0;
        RX_IN = 1'b0;
        step();
        walk_frame(16, 1'b0, 1'b0, 8'hF0, 53, 1'b0);
        RST   = 1'b1;
        RX_IN = 1'b0;
        #1;
        n_cmp++;
        if ({edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en,
             data_valid, frame_err, busy} !== 18'd0) begin
            n_err++;
            $display("FAIL reset_mid_data: got edge=%0d bit=%0d samp=%b deser=%b busy=%b want all 0",
                     edge_cnt, bit_cnt, dat_samp_en, deser_en, busy);
        end
        step();
        RST   = 1'b0;
        RX_IN = 1'b1;
        step();
        n_cmp++;
        if ({busy, data_valid, frame_err} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_no_pulse: got busy,dv,fe=%b want 000", {busy, data_valid, frame_err});
        end
    endtask

`ifdef UART_RX_BREAK_DET_EN
    task automatic test_break();
        PRESCALE = 6'd8;
        RX_IN = 1'b0;
        step();
        walk_frame(8, 1'b0, 1'b0, 8'h00, 80, 1'b1);
        step();
        stp_err = 1'b1;
        step();
        stp_err = 1'b0;
        n_cmp++;
        if ({break_det, frame_err, data_valid, busy} !== 4'b1001) begin
            n_err++;
            $display("FAIL break_pulse: got brk,fe,dv,busy=%b want 1001",
                     {break_det, frame_err, data_valid, busy});
        end
        step();
        step();
        n_cmp++;
        if ({break_det, busy} !== 2'b01) begin
            n_err++;
            $display("FAIL break_wait: got brk,busy=%b want 01", {break_det, busy});
        end
        RX_IN = 1'b1;
        step();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL break_release: got busy=%b want 0", busy);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_frame_8n1();
        test_parity_err();
        test_glitch();
        test_clamp();
        test_back_to_back();
        test_prescale_change_reset();
`ifdef UART_RX_BREAK_DET_EN
        test_break();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
